filter_coeff_sequencer: RTL and testbench
=========================================

# filter_coeff_sequencer

Per-sample consumer of the filter cutoff (F) and resonance (Q) coefficient lookup ROMs. On each sample tick it latches the 7-bit controller values, drives them as ROM addresses, and captures the registered 18-bit ROM outputs. It then slew-limits the live coefficients toward the new targets to suppress zipper noise and presents them to the state-variable filter with a one-cycle valid strobe. It sits between the MIDI CC decode and the filter datapath in the voice.

## Interface

- MAX_STEP, 18'd1024: maximum per-update change of each coefficient, unsigned. 0 disables slewing, so every update snaps to target.
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sample_tick  input  1  one-cycle pulse at the audio sample rate
- cutoff_cc  input  7  cutoff controller value, sampled on an accepted tick
- resonance_cc  input  7  resonance controller value, sampled on an accepted tick
- f_val  output  7  address to the F table (registered)
- q_val  output  7  address to the Q table (registered)
- f_result  input  18 signed  F table output, registered by the table, one clk after f_val
- q_result  input  18 signed  Q table output, registered by the table, one clk after q_val
- f_coeff  output  18 signed  live cutoff coefficient
- q_coeff  output  18 signed  live resonance coefficient
- coeff_valid  output  1  one-cycle pulse; f_coeff and q_coeff were updated this cycle
- overrun  output  1  sticky; a tick arrived while busy; cleared only by rst

## Operation

- FSM states: IDLE, FETCH, CAPT, SLEW.
- IDLE, when sample_tick=1:
  - f_val <= cutoff_cc, q_val <= resonance_cc.
  - Go to FETCH.
- FETCH: the tables register the addressed entries on this edge. Go to CAPT.
- CAPT: f_tgt <= f_result, q_tgt <= q_result. Go to SLEW.
- SLEW: update each coefficient, then go to IDLE. For each of F and Q independently:
  - d = tgt − coeff, computed as 19-bit signed.
  - If primed=0 or MAX_STEP=0: coeff <= tgt.
  - Else if d > MAX_STEP: coeff <= coeff + MAX_STEP.
  - Else if d < −MAX_STEP: coeff <= coeff − MAX_STEP.
  - Else: coeff <= tgt.
  - On the same edge: coeff_valid <= 1, primed <= 1.
- Arithmetic rules:
  - Comparisons are done in 19 bits, so no overflow at the ±2^17 extremes.
  - Because the result never passes the target, the stepped coefficient stays within the 18-bit signed range.
- primed: internal flag, cleared by reset. It makes the first update after reset snap directly to target.
- sample_tick in any state other than IDLE:
  - The tick is ignored and overrun <= 1.
  - The in-flight update completes unaffected.
- Reset values: all outputs are 0, state=IDLE, f_tgt=q_tgt=0, primed=0.
- rst asserted in any state:
  - Aborts the update; no coeff_valid pulse follows.
  - Next accepted tick snaps to target.
- cutoff_cc and resonance_cc changing between ticks have no effect until the next accepted tick.

## Timing

- Tick sampled at edge E0 (in IDLE). Then:
  - f_val/q_val are valid after E0.
  - Table results are valid after E1.
  - Targets are captured at E2.
  - f_coeff/q_coeff update and coeff_valid rises at E3; coeff_valid is high for exactly one cycle.
- Latency from tick to coefficient update: 3 clk.
- Minimum tick spacing: 4 clk. A tick on the same cycle that coeff_valid is high is accepted, because state is IDLE.
- f_coeff and q_coeff hold their value between updates.
- f_val and q_val hold the last accepted address.

## Test plan

Bench stub tables register their output one cycle after the address: f_result = val×1000, q_result = 20000 − val×100. MAX_STEP=1024 unless stated.

- Reset, then tick with cutoff_cc=10, resonance_cc=0 -> 3 clk later f_coeff=10000, q_coeff=20000, coeff_valid high for 1 cycle (snap on first update).
- From that state, cutoff_cc=20, ticks every 8 clk -> f_coeff = 11024, 12048, … 19216, then 20000 on the 10th update; q_coeff stays 20000 throughout.
- From f_coeff=20000, cutoff_cc=0, resonance_cc=127 -> first update gives f_coeff=18976 and q_coeff=18976 (target 7300). Both converge monotonically and never undershoot their targets.
- Tick asserted in FETCH and again in SLEW -> overrun=1, only one coeff_valid pulse. overrun stays set until rst.
- rst asserted during CAPT -> all outputs 0 next cycle, no coeff_valid. Next tick with cutoff_cc=5 gives f_coeff=5000 directly.
- MAX_STEP=0, cutoff_cc steps 0 -> 127 -> f_coeff jumps 0 -> 127000 in a single update.

Source files
------------

// File: rtl/filter_coeff_sequencer.sv
// Latches CC values as F/Q table addresses on a sample tick, captures the registered
// table outputs and slew-limits the live coefficients toward them (3 clk tick-to-update).
module filter_coeff_sequencer #(
    parameter logic [17:0] MAX_STEP = 18'd1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic        [6:0]  cutoff_cc,
    input  logic        [6:0]  resonance_cc,
    output logic        [6:0]  f_val,
    output logic        [6:0]  q_val,
    input  logic signed [17:0] f_result,
    input  logic signed [17:0] q_result,
    output logic signed [17:0] f_coeff,
    output logic signed [17:0] q_coeff,
    output logic               coeff_valid,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CAPT  = 2'd2,
        SLEW  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic signed [17:0] r_f_tgt;
    logic signed [17:0] r_q_tgt;
    logic               r_primed;
    logic signed [17:0] w_f_next;
    logic signed [17:0] w_q_next;

    // 19-bit difference keeps the compare exact at the 18-bit extremes; the result
    // never passes the target, so truncating back to 18 bits is lossless.
    function automatic logic signed [17:0] slew_step(
        input logic signed [17:0] tgt,
        input logic signed [17:0] cur,
        input logic               primed
    );
        logic signed [18:0] tgt_x;
        logic signed [18:0] cur_x;
        logic signed [18:0] step;
        logic signed [18:0] d;
        logic signed [18:0] nxt;
        tgt_x = {tgt[17], tgt};
        cur_x = {cur[17], cur};
        step  = $signed({1'b0, MAX_STEP});
        d     = tgt_x - cur_x;
        nxt   = tgt_x;
        if (primed && (MAX_STEP != 18'd0)) begin
            if (d > step) begin
                nxt = cur_x + step;
            end else if (d < -step) begin
                nxt = cur_x - step;
            end
        end
        return nxt[17:0];
    endfunction

    assign w_f_next = slew_step(r_f_tgt, f_coeff, r_primed);
    assign w_q_next = slew_step(r_q_tgt, q_coeff, r_primed);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sample_tick) w_next = FETCH;
            FETCH:   w_next = CAPT;
            CAPT:    w_next = SLEW;
            SLEW:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_f_tgt     <= '0;
            r_q_tgt     <= '0;
            r_primed    <= 1'b0;
            f_val       <= '0;
            q_val       <= '0;
            f_coeff     <= '0;
            q_coeff     <= '0;
            coeff_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_state     <= w_next;
            coeff_valid <= 1'b0;
            if (sample_tick) begin
                if (r_state == IDLE) begin
                    f_val <= cutoff_cc;
                    q_val <= resonance_cc;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (r_state == CAPT) begin
                r_f_tgt <= f_result;
                r_q_tgt <= q_result;
            end
            if (r_state == SLEW) begin
                f_coeff     <= w_f_next;
                q_coeff     <= w_q_next;
                coeff_valid <= 1'b1;
                r_primed    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_coeff_sequencer.sv
// Bench for filter_coeff_sequencer: stub F/Q tables, vector table of updates, and a
// scoreboard that checks value and latency of every coeff_valid pulse.
module tb_filter_coeff_sequencer;

    typedef struct {
        logic [6:0] cut;
        logic [6:0] res;
        int         exp_f;
        int         exp_q;
    } vec_t;

    typedef struct {
        int f;
        int q;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               tick1 = 1'b0;
    logic               tick2 = 1'b0;
    logic        [6:0]  cutoff = '0;
    logic        [6:0]  resonance = '0;
    logic        [6:0]  f_val1, q_val1, f_val2, q_val2;
    logic signed [17:0] f_res1, q_res1, f_res2, q_res2;
    logic signed [17:0] f_coeff1, q_coeff1, f_coeff2, q_coeff2;
    logic               valid1, valid2, overrun1, overrun2;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    filter_coeff_sequencer dut1 (
        .clk(clk), .rst(rst), .sample_tick(tick1),
        .cutoff_cc(cutoff), .resonance_cc(resonance),
        .f_val(f_val1), .q_val(q_val1),
        .f_result(f_res1), .q_result(q_res1),
        .f_coeff(f_coeff1), .q_coeff(q_coeff1),
        .coeff_valid(valid1), .overrun(overrun1)
    );

    filter_coeff_sequencer #(.MAX_STEP(18'd0)) dut2 (
        .clk(clk), .rst(rst), .sample_tick(tick2),
        .cutoff_cc(cutoff), .resonance_cc(resonance),
        .f_val(f_val2), .q_val(q_val2),
        .f_result(f_res2), .q_result(q_res2),
        .f_coeff(f_coeff2), .q_coeff(q_coeff2),
        .coeff_valid(valid2), .overrun(overrun2)
    );

    // Stub tables: registered one clk after the address.
    always @(posedge clk) begin
        f_res1 <= 18'(int'(f_val1) * 1000);
        q_res1 <= 18'(20000 - int'(q_val1) * 100);
        f_res2 <= 18'(int'(f_val2) * 1000);
        q_res2 <= 18'(20000 - int'(q_val2) * 100);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (valid1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                chk("dut1_f_coeff", int'(f_coeff1), e.f);
                chk("dut1_q_coeff", int'(q_coeff1), e.q);
                chk("dut1_latency_cycle", cyc, e.cyc);
            end
        end
        if (valid2) begin
            if (sb2.size() == 0) begin
                chk("dut2_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb2.pop_front();
                chk("dut2_f_coeff", int'(f_coeff2), e.f);
                chk("dut2_q_coeff", int'(q_coeff2), e.q);
                chk("dut2_latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_tick(input int which, input logic [6:0] c, input logic [6:0] r,
                           input int ef, input int eq);
        exp_t e;
        @(posedge clk); #1;
        cutoff = c; resonance = r;
        if (which == 1) tick1 = 1'b1; else tick2 = 1'b1;
        @(posedge clk); #1;
        tick1 = 1'b0; tick2 = 1'b0;
        e.f = ef; e.q = eq; e.cyc = cyc + 3;
        if (which == 1) sb1.push_back(e); else sb2.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (sb1.size() != 0 || sb2.size() != 0); i++) @(posedge clk);
        if (sb1.size() != 0 || sb2.size() != 0) begin
            chk({name, "_timeout_pending"}, sb1.size() + sb2.size(), 0);
            sb1.delete(); sb2.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        // First update snaps; then a ramp to 20000 in 1024 steps; then a descent of F to 0 and Q to 7300.
        tbl.push_back('{7'd10, 7'd0, 10000, 20000});
        for (int k = 1; k <= 10; k++)
            tbl.push_back('{7'd20, 7'd0, (10000 + 1024 * k > 20000) ? 20000 : 10000 + 1024 * k, 20000});
        for (int k = 1; k <= 20; k++)
            tbl.push_back('{7'd0, 7'd127, (20000 - 1024 * k < 0) ? 0 : 20000 - 1024 * k,
                            (20000 - 1024 * k < 7300) ? 7300 : 20000 - 1024 * k});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_f_coeff", int'(f_coeff1), 0);
        chk("reset_q_coeff", int'(q_coeff1), 0);
        chk("reset_valid", int'(valid1), 0);
        chk("reset_overrun", int'(overrun1), 0);
        chk("reset_f_val", int'(f_val1), 0);
        chk("reset_q_val", int'(q_val1), 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            do_tick(1, tbl[i].cut, tbl[i].res, tbl[i].exp_f, tbl[i].exp_q);
            drain("table_vector");
        end
        chk("no_overrun_after_spaced_ticks", int'(overrun1), 0);

        // Ticks during FETCH and SLEW are ignored; only one update follows.
        begin
            exp_t e;
            @(posedge clk); #1;
            cutoff = 7'd1; resonance = 7'd127; tick1 = 1'b1;
            @(posedge clk); #1;
            e.f = 1000; e.q = 7300; e.cyc = cyc + 3;
            sb1.push_back(e);
            cutoff = 7'd50; resonance = 7'd0;
            @(posedge clk); #1;
            tick1 = 1'b0;
            @(posedge clk); #1;
            tick1 = 1'b1;
            @(posedge clk); #1;
            tick1 = 1'b0;
        end
        chk("overrun_set", int'(overrun1), 1);
        chk("f_val_holds_accepted", int'(f_val1), 1);
        drain("overrun_seq");
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_sticky", int'(overrun1), 1);

        // Reset sampled while in CAPT aborts the update.
        @(posedge clk); #1;
        cutoff = 7'd30; resonance = 7'd0; tick1 = 1'b1;
        @(posedge clk); #1;
        tick1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_f_coeff", int'(f_coeff1), 0);
        chk("abort_q_coeff", int'(q_coeff1), 0);
        chk("abort_valid", int'(valid1), 0);
        chk("abort_overrun", int'(overrun1), 0);
        chk("abort_f_val", int'(f_val1), 0);
        chk("abort_q_val", int'(q_val1), 0);
        repeat (8) @(posedge clk);
        do_tick(1, 7'd5, 7'd0, 5000, 20000);
        drain("snap_after_abort");

        // MAX_STEP = 0: every update snaps to target.
        do_tick(2, 7'd0, 7'd0, 0, 20000);
        drain("nostep_first");
        do_tick(2, 7'd127, 7'd0, 127000, 20000);
        drain("nostep_jump");
        chk("nostep_overrun", int'(overrun2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
